// File: rtl/framed_shiftregister.sv
// Framed bidirectional shift register for the SPI-style datapath.
// A parallel load starts a frame; each peripheral-clock edge strobe shifts one
// bit out and one bit in. After WIDTH strobes the received word is captured
// and frameDone pulses for one cycle. In continuous mode the next frame
// starts on the received contents without a reload.
//
// state | meaning
// IDLE  | no frame in progress; strobes are ignored
// SHIFT | frame in progress; each strobe moves one bit
module framed_shiftregister #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit CONTINUOUS = 1'b0,
  parameter int CNT_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic             serialDataOut,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             frameDone,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   mem;
  logic [CNT_W-1:0]   bit_count;
  logic [WIDTH-1:0]   shift_word;
  logic               shift_out_bit;
  logic               load_out_bit;

  // Next shift-register contents and the outgoing bit for shift and load.
  always_comb begin
    shift_word    = '0;
    shift_out_bit = 1'b0;
    load_out_bit  = 1'b0;
    if (MSB_FIRST) begin
      shift_word    = {mem[WIDTH-2:0], serialDataIn};
      shift_out_bit = mem[WIDTH-2];
      load_out_bit  = parallelDataIn[WIDTH-1];
    end else begin
      shift_word    = {serialDataIn, mem[WIDTH-1:1]};
      shift_out_bit = mem[1];
      load_out_bit  = parallelDataIn[0];
    end
  end

  // Frame FSM: reset, then load (aborts any frame, drops a coincident strobe),
  // then strobe-driven shifting with explicit bit-counter wrap at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      mem             <= '0;
      bit_count       <= '0;
      serialDataOut   <= 1'b0;
      parallelDataOut <= '0;
      frameDone       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (parallelLoad) begin
        mem           <= parallelDataIn;
        bit_count     <= '0;
        serialDataOut <= load_out_bit;
        state         <= SHIFT;
        busy          <= 1'b1;
      end else if (state == SHIFT && peripheralClkEdge) begin
        mem           <= shift_word;
        serialDataOut <= shift_out_bit;
        if (bit_count == LAST_BIT) begin
          bit_count       <= '0;
          parallelDataOut <= shift_word;
          frameDone       <= 1'b1;
          if (!CONTINUOUS) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          bit_count <= bit_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_framed_shiftregister.sv
// Directed bench for framed_shiftregister: three instances share stimulus
// (MSB-first one-shot, LSB-first one-shot, MSB-first continuous).
module tb_framed_shiftregister;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stb = 1'b0;
  logic       load = 1'b0;
  logic [7:0] pdi = 8'h00;
  logic       sdi = 1'b0;

  logic [2:0] sdo;
  logic [2:0] fd;
  logic [2:0] bsy;
  logic [7:0] pdo0, pdo1, pdo2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  framed_shiftregister #(.WIDTH(8), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) u_msb (
    .clk(clk), .reset(reset), .peripheralClkEdge(stb), .parallelLoad(load),
    .parallelDataIn(pdi), .serialDataIn(sdi), .serialDataOut(sdo[0]),
    .parallelDataOut(pdo0), .frameDone(fd[0]), .busy(bsy[0]));

  framed_shiftregister #(.WIDTH(8), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .peripheralClkEdge(stb), .parallelLoad(load),
    .parallelDataIn(pdi), .serialDataIn(sdi), .serialDataOut(sdo[1]),
    .parallelDataOut(pdo1), .frameDone(fd[1]), .busy(bsy[1]));

  framed_shiftregister #(.WIDTH(8), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .reset(reset), .peripheralClkEdge(stb), .parallelLoad(load),
    .parallelDataIn(pdi), .serialDataIn(sdi), .serialDataOut(sdo[2]),
    .parallelDataOut(pdo2), .frameDone(fd[2]), .busy(bsy[2]));

  function automatic logic [7:0] pdo_of(int d);
    if (d == 0) return pdo0;
    else if (d == 1) return pdo1;
    else return pdo2;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(logic b);
    sdi = b;
    stb = 1'b1;
    step();
    stb = 1'b0;
  endtask

  // One full frame on instance d: strobes 3 cycles apart, checking the
  // outgoing bit before each strobe, the single frameDone pulse, that the
  // received word is hidden until frame end, and busy afterwards.
  task automatic frame(int d, logic [7:0] tx, logic [7:0] rx, bit msb, bit exp_busy);
    logic [7:0] pdo_start;
    int idx;
    pdo_start = pdo_of(d);
    for (int k = 0; k < 8; k++) begin
      idx = msb ? 7 - k : k;
      check($sformatf("sdo_d%0d_k%0d", d, k), sdo[d], tx[idx]);
      strobe(rx[idx]);
      check($sformatf("fd_d%0d_k%0d", d, k), fd[d], (k == 7));
      if (k < 7) check($sformatf("pdo_hold_d%0d_k%0d", d, k), pdo_of(d), pdo_start);
      step();
      check($sformatf("fd_off_d%0d_k%0d", d, k), fd[d], 1'b0);
      step();
    end
    check($sformatf("pdo_d%0d", d), pdo_of(d), rx);
    check($sformatf("busy_end_d%0d", d), bsy[d], exp_busy);
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_sdo"}, sdo, 3'b000);
    check({tag, "_fd"}, fd, 3'b000);
    check({tag, "_busy"}, bsy, 3'b000);
    check({tag, "_pdo"}, {pdo0, pdo1, pdo2}, 24'h0);
  endtask

  task automatic load_word(logic [7:0] w);
    pdi = w;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // 1: reset held two cycles with random inputs toggling
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stb  = 1'($urandom_range(1));
      load = 1'($urandom_range(1));
      sdi  = 1'($urandom_range(1));
      pdi  = 8'($urandom);
      step();
      check_cleared($sformatf("reset_c%0d", i));
    end
    reset = 1'b0;
    stb = 1'b0;
    load = 1'b0;
    sdi = 1'b0;
    step();
    check_cleared("after_reset");

    // 2: MSB-first, tx A5, rx 3C
    load_word(8'hA5);
    check("msb_busy_load", bsy[0], 1'b1);
    frame(0, 8'hA5, 8'h3C, 1'b1, 1'b0);

    // 3: LSB-first, tx 0F, rx F0
    load_word(8'h0F);
    frame(1, 8'h0F, 8'hF0, 1'b0, 1'b0);

    // 4: abort mid-frame; reload with a coincident strobe that must be dropped
    load_word(8'h11);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0);
      check($sformatf("abort_fd_%0d", i), fd[0], 1'b0);
      step();
    end
    check("abort_sdo_pre", sdo[0], 1'b1);
    pdi = 8'h22;
    load = 1'b1;
    stb = 1'b1;
    sdi = 1'b1;
    step();
    load = 1'b0;
    stb = 1'b0;
    check("abort_fd_load", fd[0], 1'b0);
    frame(0, 8'h22, 8'h5A, 1'b1, 1'b0);

    // 5a: strobes in IDLE are ignored (mem holds 5A, out bit 0)
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      check($sformatf("idle_fd_%0d", i), fd[0], 1'b0);
      check($sformatf("idle_sdo_%0d", i), sdo[0], 1'b0);
      check($sformatf("idle_busy_%0d", i), bsy[0], 1'b0);
    end
    check("idle_pdo", pdo0, 8'h5A);

    // 5b: continuous mode, two back-to-back frames from one load
    load_word(8'hC3);
    frame(2, 8'hC3, 8'h96, 1'b1, 1'b1);
    frame(2, 8'h96, 8'h4B, 1'b1, 1'b1);

    // 6: reset after 5 strobes, then strobes ignored until the next load
    load_word(8'hE7);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_cleared("mid_reset");
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      check_cleared($sformatf("post_reset_%0d", i));
    end
    load_word(8'h81);
    check("reload_sdo", sdo, 3'b111);
    check("reload_busy", bsy, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
